burst_universal_shift_register: RTL and testbench
=================================================

// Module: burst_universal_shift_register
// PURPOSE
//  Next-generation universal shift register. Datapath width is parametrised.
//  Adds rotate and arithmetic-shift modes, a registered shifted-out bit, and a
//  counted burst engine (start/busy/done). The engine applies one mode C times
//  without the mode being re-driven. Replaces the 2-select-bit register in
//  serialiser/deserialiser paths.
// PARAMETERS
//  N      8   register width in bits (N >= 2)
//  CNT_W  4   width of burst count; max burst = 2**CNT_W - 1 shifts
// PORTS
//  clk      in   1      clock, all state updates on rising edge
//  reset_n  in   1      asynchronous, active-low reset
//  enable   in   1      clock enable; 0 freezes Q, shout and FSM
//  clear    in   1      synchronous clear of Q, aborts burst
//  mode     in   3      operation select (see BEHAVIOUR)
//  start    in   1      request burst of `count` operations of `mode`
//  count    in   CNT_W  burst length, sampled with start
//  msb_in   in   1      serial input entering at Q[N-1] on shift right
//  lsb_in   in   1      serial input entering at Q[0] on shift left
//  I        in   N      parallel load data
//  Q        out  N      register contents
//  shout    out  1      last bit shifted/rotated out (registered)
//  busy     out  1      1 while burst in RUN
//  done     out  1      one-cycle pulse at burst completion
// BEHAVIOUR
//  Reset (async, reset_n=0): Q=0, shout=0, FSM=IDLE, busy=0, done=0, immediately.
//  Mode ops (one per enabled op cycle):
//   000 hold | 001 SR: Q<={msb_in,Q[N-1:1]}, shout<=Q[0]
//   010 SL: Q<={Q[N-2:0],lsb_in}, shout<=Q[N-1] | 011 load: Q<=I, shout held
//   100 ROR: Q<={Q[0],Q[N-1:1]}, shout<=Q[0] | 101 ROL: Q<={Q[N-2:0],Q[N-1]}, shout<=Q[N-1]
//   110 ASR: Q<={Q[N-1],Q[N-1:1]}, shout<=Q[0] | 111 reserved = hold
//  Priority per edge: clear > enable=0 > FSM/op.
//   clear=1: Q=0, shout held, FSM->IDLE, no done pulse. Applies regardless of enable.
//  FSM states IDLE, RUN, DONE. Edges below are enabled edges only.
//   IDLE: op = live `mode` each edge (free-run).
//    start=1 at edge t: latch mode->mode_r, count->rem; no op on edge t.
//    Next state at t: RUN if count!=0, else DONE.
//   RUN: busy=1; each edge applies mode_r and decrements rem.
//    Leave for DONE on the edge where rem goes 1->0.
//    Live mode and start are ignored. C ops occur on edges t+1..t+C.
//   DONE: done=1 for exactly one cycle; Q held; start ignored; next edge -> IDLE.
//  enable=0: no op, rem/state/shout frozen. done stays high until the next enabled edge.
//  Mode 011 in burst is legal (reloads I each edge).
//  count=0: done pulses in the cycle after edge t; Q unchanged.
//  Outputs busy/done decode directly from the state register (no extra latency).
// TESTING (N=8, CNT_W=4)
//  1 reset_n low mid-cycle during RUN -> Q=00, shout=0, busy=0, done=0 before
//    next edge; a later start with count=2 runs normally.
//  2 free-run: mode=011 I=B4 -> Q=B4; mode=100 one edge -> Q=5A shout=0;
//    load 96, mode=110 -> Q=CB shout=0; mode=001 msb_in=1 on 02 -> Q=81 shout=0.
//  3 burst: Q=81, start mode=101 count=3 -> busy 3 cycles, Q=03,06,0C;
//    done=1 one cycle; idle with Q=0C; mode toggled during RUN has no effect.
//  4 same as 3 with enable=0 for 2 cycles mid-RUN -> done 2 cycles later,
//    final Q=0C, shout unchanged while stalled.
//  5 clear during RUN (after 1 op) -> Q=00, busy=0, no done pulse.
//    start count=0 on Q=5A -> done pulse next cycle, Q=5A.
//  6 start in DONE cycle -> ignored. start with enable=0 -> not latched, busy stays 0.

Source files
------------

// File: rtl/burst_universal_shift_register_if.sv
// -----------------------------------------------------------------------------
// burst_universal_shift_register_if
//   Control and data bundle for the burst universal shift register.
//   master : the block driving operations (enable, clear, mode, start, count,
//            serial inputs, parallel load data) and observing results.
//   slave  : the shift register itself.
//   Signals:
//     enable  clock enable; 0 freezes register, shout and sequencer
//     clear   synchronous clear of the register, aborts a burst
//     mode    3-bit operation select
//     start   burst request, sampled with count
//     count   burst length
//     msb_in  serial bit entering the top on shift right
//     lsb_in  serial bit entering the bottom on shift left
//     I       parallel load data
//     Q       register contents
//     shout   last bit shifted or rotated out
//     busy    burst in progress
//     done    one-cycle burst completion pulse
// -----------------------------------------------------------------------------
interface burst_universal_shift_register_if #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) ();

  logic             enable;
  logic             clear;
  logic [2:0]       mode;
  logic             start;
  logic [CNT_W-1:0] count;
  logic             msb_in;
  logic             lsb_in;
  logic [N-1:0]     I;
  logic [N-1:0]     Q;
  logic             shout;
  logic             busy;
  logic             done;

  modport master (
    output enable, clear, mode, start, count, msb_in, lsb_in, I,
    input  Q, shout, busy, done
  );

  modport slave (
    input  enable, clear, mode, start, count, msb_in, lsb_in, I,
    output Q, shout, busy, done
  );

endinterface

// File: rtl/burst_universal_shift_register.sv
// -----------------------------------------------------------------------------
// burst_universal_shift_register
//   N-bit universal shift register with hold, shift right/left, parallel load,
//   rotate right/left and arithmetic shift right. The bit that leaves the
//   register on a shift or rotate is kept in shout.
//   A counted burst engine (IDLE -> RUN -> DONE) latches a mode and a count on
//   start and applies that mode count times without the mode being re-driven.
//   In IDLE the live mode is applied on every enabled edge.
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset
//     bus      slave side of burst_universal_shift_register_if
// -----------------------------------------------------------------------------
module burst_universal_shift_register #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  burst_universal_shift_register_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SR   = 3'b001,
    OP_SL   = 3'b010,
    OP_LOAD = 3'b011,
    OP_ROR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ASR  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  state_e           state, state_nxt;
  logic [N-1:0]     q, q_nxt;
  logic             shout, shout_nxt;
  logic [2:0]       mode_r, mode_r_nxt;
  logic [CNT_W-1:0] rem, rem_nxt;
  op_e              op;

  // ---------------------------------------------------------------------------
  // Operation select: live mode while free-running, latched mode during a
  // burst, hold on the start edge and throughout DONE.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    op = OP_HOLD;
    unique case (state)
      S_IDLE:  if (!bus.start) op = op_e'(bus.mode);
      S_RUN:   op = op_e'(mode_r);
      default: op = OP_HOLD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift/rotate/load datapath.
  // ---------------------------------------------------------------------------
  always_comb begin
    q_nxt     = q;
    shout_nxt = shout;
    unique case (op)
      OP_SR: begin
        q_nxt     = {bus.msb_in, q[N-1:1]};
        shout_nxt = q[0];
      end
      OP_SL: begin
        q_nxt     = {q[N-2:0], bus.lsb_in};
        shout_nxt = q[N-1];
      end
      OP_LOAD: q_nxt = bus.I;
      OP_ROR: begin
        q_nxt     = {q[0], q[N-1:1]};
        shout_nxt = q[0];
      end
      OP_ROL: begin
        q_nxt     = {q[N-2:0], q[N-1]};
        shout_nxt = q[N-1];
      end
      OP_ASR: begin
        // Sign bit is replicated into the vacated top position.
        q_nxt     = {q[N-1], q[N-1:1]};
        shout_nxt = q[0];
      end
      default: begin
        q_nxt     = q;
        shout_nxt = shout;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Burst sequencer: next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    mode_r_nxt = mode_r;
    rem_nxt    = rem;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          mode_r_nxt = bus.mode;
          rem_nxt    = bus.count;
          // A zero-length burst goes straight to the completion pulse.
          state_nxt  = (bus.count != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        rem_nxt = rem - CNT_W'(1);
        if (rem == CNT_W'(1)) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register. clear outranks enable, so a stalled burst can still be
  // aborted; clear leaves shout untouched.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!reset_n) begin
      state  <= S_IDLE;
      q      <= '0;
      shout  <= 1'b0;
      mode_r <= '0;
      rem    <= '0;
    end else if (bus.clear) begin
      state  <= S_IDLE;
      q      <= '0;
    end else if (bus.enable) begin
      state  <= state_nxt;
      q      <= q_nxt;
      shout  <= shout_nxt;
      mode_r <= mode_r_nxt;
      rem    <= rem_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs decode straight from the state register: no added latency, and
  // done stays high while enable is low because the state is frozen.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.busy  = (state == S_RUN);
    bus.done  = (state == S_DONE);
    bus.Q     = q;
    bus.shout = shout;
  end

endmodule

// File: tb/tb_burst_universal_shift_register.sv
// -----------------------------------------------------------------------------
// tb_burst_universal_shift_register
//   Self-checking bench for burst_universal_shift_register (N=8, CNT_W=4).
//   A behavioural model (operations as plain arithmetic, burst as an
//   operations-left counter) is advanced on every rising edge and compared
//   with the DUT one time unit later. Directed scenarios also check fixed
//   expected constants; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_burst_universal_shift_register;

  localparam int N  = 8;
  localparam int CW = 4;

  logic clk;
  logic reset_n;

  burst_universal_shift_register_if #(.N(N), .CNT_W(CW)) bus ();

  burst_universal_shift_register #(.N(N), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [N-1:0] m_q;
  logic         m_shout;
  bit           m_running;
  bit           m_done;
  int           m_left;
  logic [2:0]   m_mode;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q       = '0;
    m_shout   = 1'b0;
    m_running = 1'b0;
    m_done    = 1'b0;
    m_left    = 0;
    m_mode    = '0;
  endtask

  task automatic model_op(input logic [2:0] op);
    logic [N-1:0] top;
    top = N'(1) << (N - 1);
    case (op)
      3'd1: begin m_shout = m_q[0];   m_q = (m_q >> 1) | (bus.msb_in ? top : '0); end
      3'd2: begin m_shout = m_q[N-1]; m_q = (m_q << 1) | N'(bus.lsb_in); end
      3'd3: m_q = bus.I;
      3'd4: begin m_shout = m_q[0];   m_q = (m_q >> 1) | (m_q << (N - 1)); end
      3'd5: begin m_shout = m_q[N-1]; m_q = (m_q << 1) | (m_q >> (N - 1)); end
      3'd6: begin m_shout = m_q[0];   m_q = N'($signed(m_q) >>> 1); end
      default: ;
    endcase
  endtask

  task automatic model_edge();
    if (bus.clear) begin
      m_q       = '0;
      m_running = 1'b0;
      m_done    = 1'b0;
    end else if (bus.enable) begin
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_running) begin
        model_op(m_mode);
        m_left--;
        if (m_left == 0) begin
          m_running = 1'b0;
          m_done    = 1'b1;
        end
      end else if (bus.start) begin
        m_mode = bus.mode;
        m_left = int'(bus.count);
        if (m_left == 0) m_done = 1'b1;
        else             m_running = 1'b1;
      end else begin
        model_op(bus.mode);
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".Q"},     32'(bus.Q),     32'(m_q));
    check({tag, ".shout"}, 32'(bus.shout), 32'(m_shout));
    check({tag, ".busy"},  32'(bus.busy),  32'(m_running));
    check({tag, ".done"},  32'(bus.done),  32'(m_done));
  endtask

  // One clock: advance the model on the edge, compare shortly after.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic load(input logic [N-1:0] val);
    bus.mode = 3'b011;
    bus.I    = val;
    cycle("load");
    bus.mode = 3'b000;
  endtask

  logic [N-1:0] exp_q [3];

  initial begin
    reset_n    = 1'b0;
    bus.enable = 1'b0;
    bus.clear  = 1'b0;
    bus.mode   = '0;
    bus.start  = 1'b0;
    bus.count  = '0;
    bus.msb_in = 1'b0;
    bus.lsb_in = 1'b0;
    bus.I      = '0;
    model_reset();
    #12;
    check("rst.Q",     32'(bus.Q),     32'h0);
    check("rst.shout", 32'(bus.shout), 32'h0);
    check("rst.busy",  32'(bus.busy),  32'h0);
    check("rst.done",  32'(bus.done),  32'h0);
    reset_n    = 1'b1;
    bus.enable = 1'b1;

    // 1: async reset mid-cycle during RUN, then a normal count=2 burst
    load(8'hA5);
    bus.mode = 3'b001; bus.msb_in = 1'b1; bus.count = 4'd5; bus.start = 1'b1;
    cycle("t1_start");
    bus.start = 1'b0;
    cycle("t1_run");
    check("t1_busy_before_rst", 32'(bus.busy), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("t1_async.Q",     32'(bus.Q),     32'h0);
    check("t1_async.shout", 32'(bus.shout), 32'h0);
    check("t1_async.busy",  32'(bus.busy),  32'h0);
    check("t1_async.done",  32'(bus.done),  32'h0);
    model_reset();
    #2 reset_n = 1'b1;
    bus.mode = 3'b001; bus.msb_in = 1'b1; bus.count = 4'd2; bus.start = 1'b1;
    cycle("t1_b_start");
    bus.start = 1'b0; bus.mode = 3'b010;
    cycle("t1_b_op1");
    check("t1_b_op1_Q", 32'(bus.Q), 32'h80);
    cycle("t1_b_op2");
    check("t1_b_op2_Q",  32'(bus.Q),    32'hC0);
    check("t1_b_done",   32'(bus.done), 32'h1);
    bus.mode = 3'b000;
    cycle("t1_b_idle");

    // 2: free-run operations
    bus.mode = 3'b011; bus.I = 8'hB4;
    cycle("t2_load");
    check("t2_load_Q", 32'(bus.Q), 32'hB4);
    bus.mode = 3'b100;
    cycle("t2_ror");
    check("t2_ror_Q",     32'(bus.Q),     32'h5A);
    check("t2_ror_shout", 32'(bus.shout), 32'h0);
    load(8'h96);
    bus.mode = 3'b110;
    cycle("t2_asr");
    check("t2_asr_Q",     32'(bus.Q),     32'hCB);
    check("t2_asr_shout", 32'(bus.shout), 32'h0);
    load(8'h02);
    bus.mode = 3'b001; bus.msb_in = 1'b1;
    cycle("t2_sr");
    check("t2_sr_Q",     32'(bus.Q),     32'h81);
    check("t2_sr_shout", 32'(bus.shout), 32'h0);

    // 3: ROL burst of 3 with live mode toggled during RUN
    exp_q[0] = 8'h03; exp_q[1] = 8'h06; exp_q[2] = 8'h0C;
    bus.mode = 3'b101; bus.count = 4'd3; bus.start = 1'b1;
    cycle("t3_start");
    check("t3_start_busy", 32'(bus.busy), 32'h1);
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.mode = 3'($urandom_range(0, 7));
      cycle("t3_run");
      check("t3_run_Q", 32'(bus.Q), 32'(exp_q[i]));
    end
    check("t3_done", 32'(bus.done), 32'h1);
    bus.mode = 3'b000;
    cycle("t3_idle");
    check("t3_idle_Q",    32'(bus.Q),    32'h0C);
    check("t3_idle_done", 32'(bus.done), 32'h0);

    // 4: same burst with a two-cycle enable stall after the first op
    load(8'h81);
    bus.mode = 3'b101; bus.count = 4'd3; bus.start = 1'b1;
    cycle("t4_start");
    bus.start = 1'b0; bus.mode = 3'b001;
    cycle("t4_op1");
    bus.enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle("t4_stall");
      check("t4_stall_Q",     32'(bus.Q),     32'h03);
      check("t4_stall_shout", 32'(bus.shout), 32'h1);
      check("t4_stall_busy",  32'(bus.busy),  32'h1);
    end
    bus.enable = 1'b1;
    cycle("t4_op2");
    check("t4_op2_done", 32'(bus.done), 32'h0);
    cycle("t4_op3");
    check("t4_final_Q", 32'(bus.Q),    32'h0C);
    check("t4_done",    32'(bus.done), 32'h1);
    bus.mode = 3'b000;
    cycle("t4_idle");

    // 5: clear aborts a burst; zero-length burst
    load(8'h81);
    bus.mode = 3'b101; bus.count = 4'd5; bus.start = 1'b1;
    cycle("t5_start");
    bus.start = 1'b0;
    cycle("t5_op1");
    bus.clear = 1'b1;
    cycle("t5_clear");
    check("t5_clear_Q",    32'(bus.Q),    32'h0);
    check("t5_clear_busy", 32'(bus.busy), 32'h0);
    bus.clear = 1'b0; bus.mode = 3'b000;
    cycle("t5_after");
    check("t5_no_done", 32'(bus.done), 32'h0);
    load(8'h5A);
    bus.mode = 3'b001; bus.count = 4'd0; bus.start = 1'b1;
    cycle("t5_zero");
    check("t5_zero_done", 32'(bus.done), 32'h1);
    check("t5_zero_Q",    32'(bus.Q),    32'h5A);

    // 6: start held in the DONE cycle is ignored; start with enable low
    bus.count = 4'd3;
    cycle("t6_done_start");
    check("t6_ignored_busy", 32'(bus.busy), 32'h0);
    check("t6_ignored_Q",    32'(bus.Q),    32'h5A);
    bus.enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle("t6_noen");
      check("t6_noen_busy", 32'(bus.busy), 32'h0);
    end
    bus.enable = 1'b1; bus.start = 1'b0; bus.mode = 3'b000;
    cycle("t6_resume");
    check("t6_resume_busy", 32'(bus.busy), 32'h0);

    // Randomized phase
    for (int i = 0; i < 1500; i++) begin
      bus.enable = ($urandom_range(0, 7) != 0);
      bus.clear  = ($urandom_range(0, 29) == 0);
      bus.start  = ($urandom_range(0, 5) == 0);
      bus.mode   = 3'($urandom_range(0, 7));
      bus.count  = CW'($urandom_range(0, 15));
      bus.msb_in = 1'($urandom);
      bus.lsb_in = 1'($urandom);
      bus.I      = N'($urandom);
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
